// File: rtl/jb_predict_if.sv
`default_nettype none
// ============================================================================
//  Module   : jb_predict_if
//  Purpose  : Signal bundle between the pipeline (IF/EX) and jb_predict_unit.
//             The master modport is the pipeline side, the slave modport is
//             the predictor side.
//  Revision : 1.0  initial release
// ============================================================================
interface jb_predict_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  // IF-stage lookup
  logic [XLEN-1:0]  if_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  // EX-stage resolve
  logic             ex_valid;
  logic             ex_stall;
  logic [4:0]       ex_opcode;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_operand1;
  logic [XLEN-1:0]  ex_operand2;
  logic             ex_branch_taken;
  logic             ex_pred_taken;
  logic [XLEN-1:0]  ex_pred_target;
  logic [XLEN-1:0]  jb_out;
  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;
  // Statistics
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output if_pc, ex_valid, ex_stall, ex_opcode, ex_pc, ex_operand1,
           ex_operand2, ex_branch_taken, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, jb_out, mispredict, redirect_pc,
           br_cnt, mispred_cnt
  );

  modport slave (
    input  if_pc, ex_valid, ex_stall, ex_opcode, ex_pc, ex_operand1,
           ex_operand2, ex_branch_taken, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, jb_out, mispredict, redirect_pc,
           br_cnt, mispred_cnt
  );
endinterface
`default_nettype wire

// File: rtl/jb_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module   : jb_predict_unit
//  Purpose  : JB target adder plus direct-mapped BTB with 2-bit saturating
//             counters. IF looks up the BTB combinationally, EX resolves the
//             real outcome, raises mispredict/redirect and trains the table.
//             Keeps saturating branch and misprediction counters.
//  Revision : 1.0  initial release
// ============================================================================
module jb_predict_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  jb_predict_if.slave bus_io
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [4:0]      c_op_branch = 5'b11000;
  localparam logic [4:0]      c_op_jal    = 5'b11011;
  localparam logic [4:0]      c_op_jalr   = 5'b11001;
  localparam logic [XLEN-1:0] c_pc_step   = XLEN'(4);

  // BTB storage
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic             jump_q   [ENTRIES];

  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // ---------------- IF lookup ----------------
  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;
  logic             w_pred_taken;

  assign w_if_idx     = bus_io.if_pc[IDX_W+1:2];
  assign w_if_tag     = bus_io.if_pc[XLEN-1:IDX_W+2];
  assign w_if_hit     = valid_q[w_if_idx] && (tag_q[w_if_idx] == w_if_tag);
  assign w_pred_taken = w_if_hit && (jump_q[w_if_idx] || ctr_q[w_if_idx][1]);

  assign bus_io.pred_taken  = w_pred_taken;
  assign bus_io.pred_target = w_pred_taken ? target_q[w_if_idx]
                                           : (bus_io.if_pc + c_pc_step);

  // ---------------- EX resolve ----------------
  logic [XLEN-1:0]  w_sum;
  logic [XLEN-1:0]  w_jb;
  logic             w_is_br;
  logic             w_is_jmp;
  logic             w_act_taken;
  logic             w_upd;
  logic             w_mispredict;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;

  assign w_sum       = bus_io.ex_operand1 + bus_io.ex_operand2;
  assign w_jb        = {w_sum[XLEN-1:1], 1'b0};
  assign w_is_br     = (bus_io.ex_opcode == c_op_branch);
  assign w_is_jmp    = (bus_io.ex_opcode == c_op_jal) || (bus_io.ex_opcode == c_op_jalr);
  assign w_act_taken = w_is_jmp || (w_is_br && bus_io.ex_branch_taken);
  assign w_upd       = bus_io.ex_valid && !bus_io.ex_stall;
  assign w_mispredict = w_upd &&
                        ((bus_io.ex_pred_taken != w_act_taken) ||
                         (w_act_taken && (bus_io.ex_pred_target != w_jb)));

  assign w_ex_idx = bus_io.ex_pc[IDX_W+1:2];
  assign w_ex_tag = bus_io.ex_pc[XLEN-1:IDX_W+2];
  assign w_ex_hit = valid_q[w_ex_idx] && (tag_q[w_ex_idx] == w_ex_tag);

  assign bus_io.jb_out      = w_jb;
  assign bus_io.mispredict  = w_mispredict;
  assign bus_io.redirect_pc = w_act_taken ? w_jb : (bus_io.ex_pc + c_pc_step);
  assign bus_io.br_cnt      = br_cnt_q;
  assign bus_io.mispred_cnt = mispred_cnt_q;

  // ---------------- Table training ----------------
  logic             w_wr_en;
  logic             w_wr_valid;
  logic [XLEN-1:0]  w_wr_target;
  logic [1:0]       w_wr_ctr;
  logic             w_wr_jump;

  // Work out the new contents of the EX entry; hits keep untouched fields.
  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_valid  = valid_q[w_ex_idx];
    w_wr_target = target_q[w_ex_idx];
    w_wr_ctr    = ctr_q[w_ex_idx];
    w_wr_jump   = jump_q[w_ex_idx];
    if (w_upd) begin
      if (w_is_jmp) begin
        w_wr_en     = 1'b1;
        w_wr_valid  = 1'b1;
        w_wr_target = w_jb;
        w_wr_ctr    = 2'b11;
        w_wr_jump   = 1'b1;
      end else if (w_is_br) begin
        if (w_ex_hit) begin
          w_wr_en    = 1'b1;
          w_wr_valid = 1'b1;
          w_wr_jump  = 1'b0;
          if (bus_io.ex_branch_taken) begin
            w_wr_target = w_jb;
            if (ctr_q[w_ex_idx] != 2'b11) w_wr_ctr = ctr_q[w_ex_idx] + 2'b01;
          end else begin
            if (ctr_q[w_ex_idx] != 2'b00) w_wr_ctr = ctr_q[w_ex_idx] - 2'b01;
          end
        end else if (bus_io.ex_branch_taken) begin
          w_wr_en     = 1'b1;
          w_wr_valid  = 1'b1;
          w_wr_target = w_jb;
          w_wr_ctr    = 2'b10;
          w_wr_jump   = 1'b0;
        end
      end else if (w_ex_hit) begin
        // A non-JB instruction hitting the BTB is an alias: drop the entry.
        w_wr_en    = 1'b1;
        w_wr_valid = 1'b0;
      end
    end
  end

  // Commit the EX entry write; reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b00;
        jump_q[i]   <= 1'b0;
      end
    end else if (w_wr_en) begin
      valid_q[w_ex_idx]  <= w_wr_valid;
      tag_q[w_ex_idx]    <= w_ex_tag;
      target_q[w_ex_idx] <= w_wr_target;
      ctr_q[w_ex_idx]    <= w_wr_ctr;
      jump_q[w_ex_idx]   <= w_wr_jump;
    end
  end

  // ---------------- Statistics ----------------
  // Saturating increments: hold at all-ones instead of wrapping.
  always_comb begin
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (w_upd && (w_is_br || w_is_jmp) && (br_cnt_q != '1))
      br_cnt_d = br_cnt_q + 1'b1;
    if (w_mispredict && (mispred_cnt_q != '1))
      mispred_cnt_d = mispred_cnt_q + 1'b1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jb_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jb_predict_unit
//  Purpose  : Directed self-checking bench for jb_predict_unit. A second
//             instance with 2-bit counters exercises statistics saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jb_predict_unit;

  logic clk;
  logic rst_n;
  int   n_asserts;
  int   n_fail;

  jb_predict_if #(.XLEN(32), .CNT_W(32)) bus ();
  jb_predict_if #(.XLEN(32), .CNT_W(2))  bus2 ();

  jb_predict_unit #(.XLEN(32), .ENTRIES(16), .CNT_W(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  jb_predict_unit #(.XLEN(32), .ENTRIES(16), .CNT_W(2)) dut_sat (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus2)
  );

  // Second instance sees exactly the same stimulus.
  assign bus2.if_pc           = bus.if_pc;
  assign bus2.ex_valid        = bus.ex_valid;
  assign bus2.ex_stall        = bus.ex_stall;
  assign bus2.ex_opcode       = bus.ex_opcode;
  assign bus2.ex_pc           = bus.ex_pc;
  assign bus2.ex_operand1     = bus.ex_operand1;
  assign bus2.ex_operand2     = bus.ex_operand2;
  assign bus2.ex_branch_taken = bus.ex_branch_taken;
  assign bus2.ex_pred_taken   = bus.ex_pred_taken;
  assign bus2.ex_pred_target  = bus.ex_pred_target;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] OP_BR   = 5'b11000;
  localparam logic [4:0] OP_JAL  = 5'b11011;
  localparam logic [4:0] OP_JALR = 5'b11001;
  localparam logic [4:0] OP_ALU  = 5'b00100;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_drive(input logic [4:0] op, input logic [31:0] pc,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic taken, input logic ptaken,
                          input logic [31:0] ptarget);
    bus.ex_valid        = 1'b1;
    bus.ex_opcode       = op;
    bus.ex_pc           = pc;
    bus.ex_operand1     = a;
    bus.ex_operand2     = b;
    bus.ex_branch_taken = taken;
    bus.ex_pred_taken   = ptaken;
    bus.ex_pred_target  = ptarget;
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic exp_taken,
                        input logic [31:0] exp_target, input string tag);
    bus.if_pc = pc;
    #1;
    check({tag, "_taken"},  64'(bus.pred_taken),  64'(exp_taken));
    check({tag, "_target"}, 64'(bus.pred_target), 64'(exp_target));
  endtask

  task automatic counts(input int exp_br, input int exp_mis, input string tag);
    check({tag, "_br_cnt"},      64'(bus.br_cnt),      64'(exp_br));
    check({tag, "_mispred_cnt"}, 64'(bus.mispred_cnt), 64'(exp_mis));
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    rst_n               = 1'b0;
    bus.if_pc           = 32'h100;
    bus.ex_valid        = 1'b0;
    bus.ex_stall        = 1'b0;
    bus.ex_opcode       = OP_ALU;
    bus.ex_pc           = 32'h10;
    bus.ex_operand1     = 32'h0;
    bus.ex_operand2     = 32'h0;
    bus.ex_branch_taken = 1'b0;
    bus.ex_pred_taken   = 1'b0;
    bus.ex_pred_target  = 32'h0;
    #3;
    // Reset state
    lookup(32'h100, 1'b0, 32'h104, "rst_lookup");
    check("rst_mispredict", 64'(bus.mispredict), 64'(1'b0));
    check("rst_redirect", 64'(bus.redirect_pc), 64'(32'h14));
    counts(0, 0, "rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // JAL at 0x100 -> 0x120, not predicted
    ex_drive(OP_JAL, 32'h100, 32'h100, 32'h20, 1'b0, 1'b0, 32'h0);
    check("jal_jb_out", 64'(bus.jb_out), 64'(32'h120));
    check("jal_mispredict", 64'(bus.mispredict), 64'(1'b1));
    check("jal_redirect", 64'(bus.redirect_pc), 64'(32'h120));
    tick();
    bus.ex_valid = 1'b0;
    lookup(32'h100, 1'b1, 32'h120, "jal_lookup");
    counts(1, 1, "jal");

    // JALR at 0x204 (index 1), odd sum has bit0 cleared, correctly predicted
    ex_drive(OP_JALR, 32'h204, 32'h2003, 32'h4, 1'b0, 1'b1, 32'h2006);
    check("jalr_jb_out", 64'(bus.jb_out), 64'(32'h2006));
    check("jalr_mispredict", 64'(bus.mispredict), 64'(1'b0));
    tick();
    bus.ex_valid = 1'b0;
    lookup(32'h204, 1'b1, 32'h2006, "jalr_lookup");
    counts(2, 1, "jalr");

    // Branch at 0x40 -> 0x80: T,T,N,N,N (index 0, replaces the JAL entry)
    ex_drive(OP_BR, 32'h40, 32'h40, 32'h40, 1'b1, 1'b0, 32'h0);
    check("br_t1_mispredict", 64'(bus.mispredict), 64'(1'b1));
    tick();
    lookup(32'h40, 1'b1, 32'h80, "br_t1_lookup");
    lookup(32'h100, 1'b0, 32'h104, "br_t1_jal_gone");
    ex_drive(OP_BR, 32'h40, 32'h40, 32'h40, 1'b1, 1'b1, 32'h80);
    check("br_t2_mispredict", 64'(bus.mispredict), 64'(1'b0));
    tick();
    lookup(32'h40, 1'b1, 32'h80, "br_t2_lookup");
    ex_drive(OP_BR, 32'h40, 32'h40, 32'h40, 1'b0, 1'b1, 32'h80);
    check("br_n1_mispredict", 64'(bus.mispredict), 64'(1'b1));
    check("br_n1_redirect", 64'(bus.redirect_pc), 64'(32'h44));
    tick();
    lookup(32'h40, 1'b1, 32'h80, "br_n1_lookup");
    ex_drive(OP_BR, 32'h40, 32'h40, 32'h40, 1'b0, 1'b1, 32'h80);
    tick();
    lookup(32'h40, 1'b0, 32'h44, "br_n2_lookup");
    ex_drive(OP_BR, 32'h40, 32'h40, 32'h40, 1'b0, 1'b0, 32'h0);
    check("br_n3_mispredict", 64'(bus.mispredict), 64'(1'b0));
    tick();
    bus.ex_valid = 1'b0;
    lookup(32'h40, 1'b0, 32'h44, "br_n3_lookup");
    counts(7, 4, "br");

    // Alias: taken branch at 0x80 overwrites index 0
    ex_drive(OP_BR, 32'h80, 32'h80, 32'h10, 1'b1, 1'b0, 32'h0);
    tick();
    lookup(32'h40, 1'b0, 32'h44, "alias_old_miss");
    lookup(32'h80, 1'b1, 32'h90, "alias_new_hit");
    ex_drive(OP_ALU, 32'h80, 32'h1, 32'h2, 1'b0, 1'b1, 32'h90);
    check("alias_mispredict", 64'(bus.mispredict), 64'(1'b1));
    check("alias_redirect", 64'(bus.redirect_pc), 64'(32'h84));
    tick();
    bus.ex_valid = 1'b0;
    lookup(32'h80, 1'b0, 32'h84, "alias_invalidated");
    counts(8, 6, "alias");

    // Stall: taken branch at 0x300 -> 0x400, mispredicted
    bus.ex_stall = 1'b1;
    ex_drive(OP_BR, 32'h300, 32'h300, 32'h100, 1'b1, 1'b0, 32'h0);
    check("stall_mispredict", 64'(bus.mispredict), 64'(1'b0));
    tick();
    lookup(32'h300, 1'b0, 32'h304, "stall_no_write");
    counts(8, 6, "stall");
    bus.ex_stall = 1'b0;
    #1;
    check("unstall_mispredict", 64'(bus.mispredict), 64'(1'b1));
    tick();
    bus.ex_valid = 1'b0;
    lookup(32'h300, 1'b1, 32'h400, "unstall_lookup");
    counts(9, 7, "unstall");

    // Same-cycle lookup/update of one index: lookup sees old contents
    ex_drive(OP_JAL, 32'h500, 32'h500, 32'h8, 1'b0, 1'b0, 32'h0);
    lookup(32'h500, 1'b0, 32'h504, "same_cycle_old");
    tick();
    bus.ex_valid = 1'b0;
    lookup(32'h500, 1'b1, 32'h508, "same_cycle_new");
    counts(10, 8, "same_cycle");

    // 2-bit statistics counters must saturate at 3
    check("sat_br_cnt", 64'(bus2.br_cnt), 64'(2'b11));
    check("sat_mispred_cnt", 64'(bus2.mispred_cnt), 64'(2'b11));

    // Asynchronous reset mid-run, no clock edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    lookup(32'h100, 1'b0, 32'h104, "arst_lookup100");
    lookup(32'h204, 1'b0, 32'h208, "arst_lookup204");
    lookup(32'h500, 1'b0, 32'h504, "arst_lookup500");
    counts(0, 0, "arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/jb_predict_unit.md
Name: jb_predict_unit

Overview:
- Parametrised successor to the CPU's jump/branch target adder.
- Still computes the resolved JB target (operand1+operand2 with bit0 cleared) in EX.
- Adds a direct-mapped branch target buffer with 2-bit saturating counters, looked up by IF.
- Generates mispredict/redirect for the pipeline flush and keeps branch/mispredict statistics counters.

Parameters:
XLEN, 32, datapath/PC width
ENTRIES, 16, BTB entries, power of two ≥ 2; IDX_W = log2(ENTRIES)
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
if_pc  in  XLEN  fetch PC for lookup
pred_taken  out  1  IF prediction: redirect fetch
pred_target  out  XLEN  predicted next PC
ex_valid  in  1  EX holds a real instruction
ex_stall  in  1  EX frozen this cycle
ex_opcode  in  5  instr[6:2]
ex_pc  in  XLEN  PC of EX instruction
ex_operand1  in  XLEN  target adder operand 1
ex_operand2  in  XLEN  target adder operand 2
ex_branch_taken  in  1  branch condition result
ex_pred_taken  in  1  prediction carried from IF
ex_pred_target  in  XLEN  target carried from IF
jb_out  out  XLEN  (ex_operand1+ex_operand2) & ~1
mispredict  out  1  flush request
redirect_pc  out  XLEN  correct next PC
br_cnt  out  CNT_W  resolved JB instructions
mispred_cnt  out  CNT_W  mispredictions

Behaviour:
- Entry fields: valid, tag = pc[XLEN-1:IDX_W+2], target[XLEN], ctr[1:0], is_jump.
- Index: pc[IDX_W+1:2]. Opcodes: 11000 branch, 11011 JAL, 11001 JALR; anything else is non-JB.
- Reset (async, rst_n=0): all valid bits clear, ctr=00, br_cnt=0, mispred_cnt=0, immediately.
- After reset: pred_taken=0, pred_target=if_pc+4, mispredict=0, redirect_pc=ex_pc+4. jb_out stays combinational.
- Lookup (combinational, zero latency):
  - hit = valid && tag match.
  - pred_taken = hit && (is_jump || ctr[1]).
  - pred_target = pred_taken ? target : if_pc+4.
- Resolve (combinational):
  - act_taken = 1 for JAL/JALR; ex_branch_taken for branch; 0 for non-JB.
  - act_target = act_taken ? jb_out : ex_pc+4.
  - upd = ex_valid && !ex_stall.
  - mispredict = upd && ((ex_pred_taken != act_taken) || (act_taken && ex_pred_target != jb_out)).
  - redirect_pc = act_target.
- Table update at posedge clk when upd; EX entry looked up by ex_pc:
  - Branch, hit: ctr saturating +1 if taken, -1 if not (11 and 00 hold). If taken, target<=jb_out. is_jump<=0.
  - Branch, miss, taken: allocate/overwrite: valid=1, tag, target=jb_out, ctr=10, is_jump=0.
  - Branch, miss, not taken: no write.
  - JAL/JALR: allocate/overwrite: valid=1, tag, target=jb_out, ctr=11, is_jump=1.
  - Non-JB, hit (alias): valid<=0.
  - Non-JB, miss: no write.
- Statistics:
  - br_cnt +1 on upd with JB opcode.
  - mispred_cnt +1 when mispredict.
  - Both saturate at all-ones and never wrap.
- Same-cycle lookup and update of one index: lookup returns pre-update contents. No bypass.
- ex_stall=1: no table write, no counter change, mispredict=0.

Test Plan:
- Reset: pulse rst_n low mid-run after populating entries; lookup if_pc=0x100 -> pred_taken=0, pred_target=0x104; br_cnt=mispred_cnt=0 without a clock edge.
- JAL: ex_pc=0x100, op1=0x100, op2=0x20, ex_pred_taken=0 -> jb_out=0x120, mispredict=1, redirect_pc=0x120. Next cycle lookup 0x100 -> pred_taken=1, pred_target=0x120; br_cnt=1, mispred_cnt=1.
- JALR: op1=0x2003, op2=0x4 -> jb_out=0x2006 (bit0 cleared). With ex_pred_taken=1 and ex_pred_target=0x2006 -> mispredict=0.
- Branch at 0x40, target 0x80: sequence T,T,N,N,N gives ctr 10,11,10,01,00. Lookup 0x40 after the 3rd N -> pred_taken=0. After the 2nd N (ctr=01) -> pred_taken=0. After the 1st N (ctr=10) -> pred_taken=1.
- Alias (ENTRIES=16): taken branch at 0x80 overwrites index 0 held by 0x40; lookup 0x40 -> miss, pred_target=0x44. A non-JB at 0x80 with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x84, entry invalidated.
- Stall: ex_valid=1, ex_stall=1, taken branch mispredicted -> mispredict=0, no counter or table change. Releasing the stall -> mispredict=1 and a single update.
